// File: rtl/flipflop_checker_pkg.sv
// -----------------------------------------------------------------------------
// flipflop_checker_pkg
// Shared definitions for the flip-flop response checker: FSM state encodings
// and the legal LATENCY range, with a helper used for elaboration-time checks.
// -----------------------------------------------------------------------------
package flipflop_checker_pkg;

    // FSM state encodings
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    // Legal DUT latency range in clock cycles
    localparam int unsigned LatencyMin = 1;
    localparam int unsigned LatencyMax = 8;

    function automatic bit latency_legal(input int unsigned lat);
        return (lat >= LatencyMin) && (lat <= LatencyMax);
    endfunction

endpackage

// File: rtl/flipflop_delay_line.sv
// -----------------------------------------------------------------------------
// flipflop_delay_line
// Fixed-length pipeline that delays a stimulus word and its valid bit by
// LATENCY cycles. Invalid slots propagate as bubbles; nothing is compacted.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset, clears the valid bits only
//   in_valid   in_data is a valid sample this cycle
//   in_data    sample entering stage 1
//   out_valid  valid bit of the last stage
//   out_data   data of the last stage
// -----------------------------------------------------------------------------
module flipflop_delay_line
    import flipflop_checker_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (!latency_legal(LATENCY)) begin : g_latency_check
        $error("flipflop_delay_line: LATENCY must be within 1..8");
    end

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [WIDTH-1:0]   data_q [LATENCY];
    logic [WIDTH-1:0]   data_d [LATENCY];

    always_comb begin
        valid_d[0] = in_valid;
        data_d[0]  = in_data;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Data is qualified by the valid bits, so it needs no reset
    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/flipflop_checker.sv
// -----------------------------------------------------------------------------
// flipflop_checker
// Response checker for a registered DUT. Accepted stimulus words are delayed
// by LATENCY cycles and compared against dut_q. Counts mismatches (saturating),
// captures the first failing sample and reports pass/fail at the end of a run.
//
// Ports:
//   clk            system clock, rising edge
//   reset          asynchronous active-low reset
//   start          one-cycle pulse arming a run (ignored while busy)
//   num_samples    number of samples to check, sampled on start
//   stim           stimulus word as applied to the DUT
//   stim_valid     stim is a valid sample this cycle
//   dut_q          DUT registered output
//   busy           run in progress
//   done           run complete, results stable
//   pass           run completed with no mismatches
//   err_count      saturating mismatch count
//   first_err_exp  expected value at the first mismatch
//   first_err_got  dut_q value at the first mismatch
//   first_err_idx  0-based sample index of the first mismatch
// -----------------------------------------------------------------------------
module flipflop_checker
    import flipflop_checker_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned LATENCY = 1,
    parameter int unsigned CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic [WIDTH-1:0] stim,
    input  logic             stim_valid,
    input  logic [WIDTH-1:0] dut_q,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] err_count,
    output logic [WIDTH-1:0] first_err_exp,
    output logic [WIDTH-1:0] first_err_got,
    output logic [CNT_W-1:0] first_err_idx
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] checked_q, checked_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [WIDTH-1:0] got_q, got_d;
    logic             pass_q, pass_d;

    logic             accept;
    logic             dl_valid;
    logic [WIDTH-1:0] dl_data;
    logic             compare;
    logic             mismatch;

    // Samples beyond the target are dropped before entering the pipeline
    assign accept = (state_q == StRun) && stim_valid && (issued_q < target_q);

    flipflop_delay_line #(
        .WIDTH   (WIDTH),
        .LATENCY (LATENCY)
    ) u_delay_line (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (accept),
        .in_data   (stim),
        .out_valid (dl_valid),
        .out_data  (dl_data)
    );

    assign compare  = (state_q == StRun) && dl_valid;
    assign mismatch = compare && (dut_q != dl_data);

    always_comb begin
        state_d   = state_q;
        target_d  = target_q;
        issued_d  = issued_q;
        checked_d = checked_q;
        err_d     = err_q;
        idx_d     = idx_q;
        exp_d     = exp_q;
        got_d     = got_q;
        pass_d    = pass_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    target_d  = num_samples;
                    issued_d  = '0;
                    checked_d = '0;
                    err_d     = '0;
                    idx_d     = '0;
                    exp_d     = '0;
                    got_d     = '0;
                    if (num_samples == '0) begin
                        state_d = StDone;
                        pass_d  = 1'b1;
                    end else begin
                        state_d = StRun;
                        pass_d  = 1'b0;
                    end
                end
            end
            StRun: begin
                if (accept) begin
                    issued_d = issued_q + CntOne;
                end
                if (compare) begin
                    checked_d = checked_q + CntOne;
                    if (mismatch) begin
                        // err_q never returns to zero within a run, so zero marks the first miss
                        if (err_q == '0) begin
                            exp_d = dl_data;
                            got_d = dut_q;
                            idx_d = checked_q;
                        end
                        if (err_q != CntMax) begin
                            err_d = err_q + CntOne;
                        end
                    end
                    // Final compare is folded into err_d before pass is decided
                    if (checked_d == target_q) begin
                        state_d = StDone;
                        pass_d  = (err_d == '0);
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            target_q  <= '0;
            issued_q  <= '0;
            checked_q <= '0;
            err_q     <= '0;
            idx_q     <= '0;
            exp_q     <= '0;
            got_q     <= '0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            issued_q  <= issued_d;
            checked_q <= checked_d;
            err_q     <= err_d;
            idx_q     <= idx_d;
            exp_q     <= exp_d;
            got_q     <= got_d;
            pass_q    <= pass_d;
        end
    end

    assign busy          = (state_q == StRun);
    assign done          = (state_q == StDone);
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_exp = exp_q;
    assign first_err_got = got_q;
    assign first_err_idx = idx_q;

endmodule

// File: tb/tb_flipflop_checker.sv
// -----------------------------------------------------------------------------
// tb_flipflop_checker
// Three checker instances share one stimulus stream:
//   dut 0: LATENCY=1, CNT_W=8   dut 1: LATENCY=3, CNT_W=8   dut 2: LATENCY=1, CNT_W=2
// Each gets its own dut_q built from the stimulus history (optionally
// corrupted). Expected results come from a sample-list model: the first
// target valid stims after start, each paired with dut_q LATENCY cycles later.
// -----------------------------------------------------------------------------
module tb_flipflop_checker;

    localparam int NK   = 3;
    localparam int MAXT = 64;
    localparam int MAXS = 16;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [7:0] num8;
    logic [1:0] num2;
    logic [3:0] stim;
    logic       stim_valid;
    logic [3:0] q0, q1, q2;

    logic       busy0, done0, pass0, busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0] err0, idx0, err1, idx1;
    logic [1:0] err2, idx2;
    logic [3:0] fe0, fg0, fe1, fg1, fe2, fg2;

    int checks = 0;
    int errors = 0;

    // Per-run stimulus history and model
    logic [3:0] stim_a [MAXT];
    bit         sv_a   [MAXT];
    bit         st_a   [MAXT];
    logic [3:0] q_a    [NK][MAXT];
    int         tgt    [NK];
    int         clast  [NK];
    int         cmp_cyc[NK][MAXS];
    logic [3:0] exp_v  [NK][MAXS];
    logic [3:0] got_v  [NK][MAXS];

    always #5 clk = ~clk;

    flipflop_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset_n), .start(start), .num_samples(num8), .stim(stim),
        .stim_valid(stim_valid), .dut_q(q0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(err0), .first_err_exp(fe0), .first_err_got(fg0), .first_err_idx(idx0)
    );

    flipflop_checker #(.WIDTH(4), .LATENCY(3), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset_n), .start(start), .num_samples(num8), .stim(stim),
        .stim_valid(stim_valid), .dut_q(q1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .first_err_exp(fe1), .first_err_got(fg1), .first_err_idx(idx1)
    );

    flipflop_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(2)) u_dut2 (
        .clk(clk), .reset(reset_n), .start(start), .num_samples(num2), .stim(stim),
        .stim_valid(stim_valid), .dut_q(q2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .first_err_exp(fe2), .first_err_got(fg2), .first_err_idx(idx2)
    );

    function automatic int lat_of(input int k);
        return (k == 1) ? 3 : 1;
    endfunction

    function automatic int cw_of(input int k);
        return (k == 2) ? 2 : 8;
    endfunction

    task automatic chk(input string tag, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s dut%0d observed %0h expected %0h", tag, k, got, exp);
        end
    endtask

    task automatic get_obs(input int k, output logic o_busy, output logic o_done,
                           output logic o_pass, output logic [31:0] o_err,
                           output logic [31:0] o_idx, output logic [31:0] o_fe,
                           output logic [31:0] o_fg);
        case (k)
            0: begin
                o_busy = busy0; o_done = done0; o_pass = pass0; o_err = 32'(err0);
                o_idx = 32'(idx0); o_fe = 32'(fe0); o_fg = 32'(fg0);
            end
            1: begin
                o_busy = busy1; o_done = done1; o_pass = pass1; o_err = 32'(err1);
                o_idx = 32'(idx1); o_fe = 32'(fe1); o_fg = 32'(fg1);
            end
            default: begin
                o_busy = busy2; o_done = done2; o_pass = pass2; o_err = 32'(err2);
                o_idx = 32'(idx2); o_fe = 32'(fe2); o_fg = 32'(fg2);
            end
        endcase
    endtask

    task automatic check_zero(input string tag);
        logic o_busy, o_done, o_pass;
        logic [31:0] o_err, o_idx, o_fe, o_fg;
        for (int k = 0; k < NK; k++) begin
            get_obs(k, o_busy, o_done, o_pass, o_err, o_idx, o_fe, o_fg);
            chk({tag, "_busy"}, k, 32'(o_busy), 32'd0);
            chk({tag, "_done"}, k, 32'(o_done), 32'd0);
            chk({tag, "_pass"}, k, 32'(o_pass), 32'd0);
            chk({tag, "_err"}, k, o_err, 32'd0);
            chk({tag, "_idx"}, k, o_idx, 32'd0);
            chk({tag, "_exp"}, k, o_fe, 32'd0);
            chk({tag, "_got"}, k, o_fg, 32'd0);
        end
    endtask

    // Expected outputs right after edge t of the current run
    task automatic check_state(input int k, input int t);
        logic o_busy, o_done, o_pass;
        logic [31:0] o_err, o_idx, o_fe, o_fg;
        int cnt, fi, sat;
        logic [3:0] fe, fg;
        bit busy_e;
        cnt = 0; fi = -1; fe = '0; fg = '0;
        for (int i = 0; i < tgt[k]; i++) begin
            if (cmp_cyc[k][i] <= t && exp_v[k][i] !== got_v[k][i]) begin
                if (fi < 0) begin
                    fi = i; fe = exp_v[k][i]; fg = got_v[k][i];
                end
                cnt++;
            end
        end
        sat = (1 << cw_of(k)) - 1;
        busy_e = (tgt[k] != 0) && (t < clast[k]);
        get_obs(k, o_busy, o_done, o_pass, o_err, o_idx, o_fe, o_fg);
        chk("busy", k, 32'(o_busy), 32'(busy_e));
        chk("done", k, 32'(o_done), 32'(!busy_e));
        chk("pass", k, 32'(o_pass), 32'(!busy_e && cnt == 0));
        chk("err_count", k, o_err, 32'((cnt > sat) ? sat : cnt));
        chk("first_idx", k, o_idx, 32'((fi < 0) ? 0 : fi));
        chk("first_exp", k, o_fe, 32'(fe));
        chk("first_got", k, o_fg, 32'(fg));
    endtask

    // mode 0: random with sporadic corruption; 1: directed 1110,0001,1110 clean;
    // 2: as 1 with sample 1 seen as 0000; 3: random with every dut_q corrupted
    task automatic run_case(input int n, input int mode);
        int T, minc, cnt, L;
        bit anyzero;
        logic [3:0] base;
        for (int t = 0; t < MAXT; t++) begin
            stim_a[t] = 4'($urandom);
            sv_a[t]   = (t == 0) ? 1'b0 : ((t > 20) ? 1'b1 : ($urandom_range(0, 2) != 0));
            st_a[t]   = 1'b0;
        end
        if (mode == 1 || mode == 2) begin
            stim_a[1] = 4'b1110; stim_a[2] = 4'b0001; stim_a[3] = 4'b1110;
            sv_a[1] = 1'b1; sv_a[2] = 1'b1; sv_a[3] = 1'b1;
        end
        for (int k = 0; k < NK; k++) begin
            L = lat_of(k);
            for (int t = 0; t < MAXT; t++) begin
                base = (t >= L) ? stim_a[t-L] : 4'($urandom);
                if ((mode == 0 && $urandom_range(0, 3) == 0) || mode == 3) begin
                    base = base ^ 4'($urandom_range(1, 15));
                end
                if (mode == 2 && t == 2 + L) begin
                    base = 4'b0000;
                end
                q_a[k][t] = base;
            end
        end
        // Sample-list model
        anyzero = 1'b0; minc = MAXT; T = 0;
        for (int k = 0; k < NK; k++) begin
            L = lat_of(k);
            tgt[k] = n % (1 << cw_of(k));
            cnt = 0;
            for (int t = 1; t < MAXT - L; t++) begin
                if (sv_a[t] && cnt < tgt[k]) begin
                    cmp_cyc[k][cnt] = t + L;
                    exp_v[k][cnt]   = stim_a[t];
                    got_v[k][cnt]   = q_a[k][t+L];
                    cnt++;
                end
            end
            clast[k] = (tgt[k] == 0) ? 0 : cmp_cyc[k][tgt[k]-1];
            if (tgt[k] == 0) anyzero = 1'b1;
            if (clast[k] < minc) minc = clast[k];
            if (clast[k] + 2 > T) T = clast[k] + 2;
        end
        st_a[0] = 1'b1;
        // Extra start pulses only while every instance is still running
        if (!anyzero) begin
            for (int t = 1; t < minc; t++) st_a[t] = ($urandom_range(0, 3) == 0);
        end
        for (int t = 0; t <= T; t++) begin
            @(negedge clk);
            start = st_a[t]; num8 = 8'(n); num2 = 2'(n);
            stim = stim_a[t]; stim_valid = sv_a[t];
            q0 = q_a[0][t]; q1 = q_a[1][t]; q2 = q_a[2][t];
            @(posedge clk);
            #1;
            for (int k = 0; k < NK; k++) check_state(k, t);
        end
    endtask

    initial begin
        reset_n = 1'b0; start = 1'b0; num8 = '0; num2 = '0;
        stim = '0; stim_valid = 1'b0; q0 = '0; q1 = '0; q2 = '0;
        #1;
        check_zero("reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        run_case(3, 1);        // clean directed run
        run_case(3, 2);        // single mismatch at index 1
        run_case(0, 0);        // zero-sample run
        run_case(3, 3);        // all wrong
        run_case(3, 3);        // re-arm clears the count
        run_case(5, 3);

        // Reset mid-run with valid samples inside the delay lines
        @(negedge clk);
        start = 1'b1; num8 = 8'd3; num2 = 2'd3; stim_valid = 1'b0;
        @(negedge clk);
        start = 1'b0; stim = 4'b1110; stim_valid = 1'b1;
        @(negedge clk);
        stim = 4'b0001;
        @(negedge clk);
        stim_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        check_zero("async_reset");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        run_case(3, 1);

        for (int i = 0; i < 12; i++) begin
            run_case(int'($urandom_range(0, 10)), 0);
        end
        run_case(4, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
